// File: rtl/dpram_fifo_ctrl.sv
// ============================================================================
// Module: dpram_fifo_ctrl
//
// Purpose:
//   Upstream controller that turns the dual_port_ram wrapper into a FIFO.
//   RAM port 1 is used only for writes and RAM port 2 only for reads. Both the
//   producer and the consumer side use valid/ready handshakes. A registered
//   output stage (out_data) isolates the consumer from the RAM read path.
//   The RAM has a 1-cycle registered read, so a word moves from RAM to the
//   consumer in two steps: issue the address (fetch), then capture ram_out2.
//
// Parameters:
//   WIDTH  data bit width (must match the RAM data width)
//   DEPTH  address bits; capacity is 2**DEPTH words
//
// Ports:
//   clock      in   1        clock; all state updates on posedge
//   reset_n    in   1        synchronous, active-low reset
//   in_valid   in   1        producer offers in_data
//   in_ready   out  1        controller accepts a word this cycle
//   in_data    in   WIDTH    write word
//   out_valid  out  1        out_data holds a valid word
//   out_ready  in   1        consumer takes out_data this cycle
//   out_data   out  WIDTH    read word (registered)
//   count      out  DEPTH+1  occupancy (unread RAM words + output stage)
//   ram_we1    out  1        RAM port-1 write enable
//   ram_addr1  out  DEPTH    RAM port-1 address (write pointer)
//   ram_data1  out  WIDTH    RAM port-1 write data (in_data)
//   ram_we2    out  1        RAM port-2 write enable, always 0
//   ram_addr2  out  DEPTH    RAM port-2 address (read pointer)
//   ram_out2   in   WIDTH    RAM port-2 read data, valid 1 cycle after address
// ============================================================================
module dpram_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH:0]   count,
    output logic             ram_we1,
    output logic [DEPTH-1:0] ram_addr1,
    output logic [WIDTH-1:0] ram_data1,
    output logic             ram_we2,
    output logic [DEPTH-1:0] ram_addr2,
    input  logic [WIDTH-1:0] ram_out2
);

    localparam int CAPACITY = 2 ** DEPTH;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_VALID
    } rstate_t;

    rstate_t rstate;
    rstate_t rstate_next;

    // Pointers carry one extra bit so that "all slots unread" and "nothing
    // unread" are distinguishable even though both map to the same address.
    logic [DEPTH:0] wr_ptr;
    logic [DEPTH:0] rd_ptr;
    logic [DEPTH:0] unread;

    logic has_unread;
    logic holding;
    logic full;
    logic push;
    logic fetch;

    assign unread     = wr_ptr - rd_ptr;
    assign has_unread = (unread != '0);

    // A word that has left the RAM but not yet been taken by the consumer is
    // still in the FIFO, whether it is in flight (R_FETCH) or in out_data.
    assign holding = (rstate == R_FETCH) || (rstate == R_VALID);
    assign count   = unread + {{DEPTH{1'b0}}, holding};

    assign full     = (count == (DEPTH + 1)'(CAPACITY));
    assign in_ready = !full && reset_n;
    assign push     = in_valid && in_ready;

    assign ram_we1   = push;
    assign ram_addr1 = wr_ptr[DEPTH-1:0];
    assign ram_data1 = in_data;
    assign ram_we2   = 1'b0;
    assign ram_addr2 = rd_ptr[DEPTH-1:0];

    // Read-side FSM next state. Issuing a fetch means the RAM captures the
    // current rd_ptr address at this edge while rd_ptr advances, so the data
    // shows up on ram_out2 during R_FETCH.
    always_comb begin
        rstate_next = rstate;
        fetch       = 1'b0;
        out_valid   = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (has_unread) begin
                    fetch       = 1'b1;
                    rstate_next = R_FETCH;
                end
            end
            R_FETCH: begin
                rstate_next = R_VALID;
            end
            R_VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (has_unread) begin
                        fetch       = 1'b1;
                        rstate_next = R_FETCH;
                    end else begin
                        rstate_next = R_IDLE;
                    end
                end
            end
            default: begin
                rstate_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_next;
        end
    end

    // Pushes and fetches are independent; both pointers may move at one edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (DEPTH + 1)'(1);
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + (DEPTH + 1)'(1);
            end
        end
    end

    // out_data changes only when a freshly read word is captured, so it stays
    // stable for as long as the consumer stalls in R_VALID.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_data <= '0;
        end else if (rstate == R_FETCH) begin
            out_data <= ram_out2;
        end
    end

endmodule
